// File: rtl/rom_arb_pkg.sv
// Shared types for the ROM arbiter: port index, response-slot state, default ROM depth.
package rom_arb_pkg;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_t;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    INFLIGHT = 2'd1,
    HELD     = 2'd2
  } slot_state_t;

  localparam int ROM_WORDS_DEFAULT = 32;

endpackage

// File: rtl/rom_resp_slot.sv
// One port's response slot: ROM data passes straight through the cycle after grant (1-cycle latency);
// when the consumer stalls, the word is parked in a hold register and the slot blocks new grants.
module rom_resp_slot
  import rom_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gnt,
  input  logic              gnt_err,
  input  logic              rready,
  input  logic [DATA_W-1:0] rom_rd,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              empty,
  output logic              inflight
);

  slot_state_t       state;
  slot_state_t       state_nxt;
  logic              err_q;
  logic [DATA_W-1:0] hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      err_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      state <= state_nxt;
      if (gnt) begin
        err_q <= gnt_err;
      end
      if (state == INFLIGHT && !rready) begin
        hold_q <= rom_rd;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rvalid    = 1'b0;
    rdata     = '0;
    unique case (state)
      EMPTY: begin
        if (gnt) begin
          state_nxt = INFLIGHT;
        end
      end
      INFLIGHT: begin
        rvalid = 1'b1;
        rdata  = err_q ? '0 : rom_rd;
        // A same-cycle regrant keeps the slot busy with the next word.
        if (rready) begin
          state_nxt = gnt ? INFLIGHT : EMPTY;
        end else begin
          state_nxt = HELD;
        end
      end
      HELD: begin
        rvalid = 1'b1;
        rdata  = err_q ? '0 : hold_q;
        if (rready) begin
          state_nxt = EMPTY;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  assign err      = rvalid & err_q;
  assign empty    = (state == EMPTY);
  assign inflight = (state == INFLIGHT);

endmodule

// File: rtl/rom_arbiter.sv
// Shares a sync-read ROM between fetch and LSU: one grant per cycle, response 1 cycle after grant.
// A stalled response is held in its slot and blocks that port's grants; conflicts go to the last loser.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ROM_WORDS = ROM_WORDS_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_GNT,
  output logic              IF_RVALID,
  output logic [DATA_W-1:0] IF_RDATA,
  output logic              IF_ERR,
  input  logic              IF_RREADY,
  input  logic              LS_REQ,
  input  logic [ADDR_W-1:0] LS_ADDR,
  output logic              LS_GNT,
  output logic              LS_RVALID,
  output logic [DATA_W-1:0] LS_RDATA,
  output logic              LS_ERR,
  input  logic              LS_RREADY,
  output logic [ADDR_W-1:0] ROM_A,
  input  logic [DATA_W-1:0] ROM_RD
);

  localparam logic [ADDR_W:0] ROM_LIMIT = (ADDR_W + 1)'(ROM_WORDS) << 2;

  logic              if_empty;
  logic              if_inflight;
  logic              ls_empty;
  logic              ls_inflight;
  logic              elig_if;
  logic              elig_ls;
  logic              conflict;
  logic              favor_ls;
  logic              win_vld;
  port_t             winner;
  logic [ADDR_W-1:0] win_addr;
  logic              win_err;

  // An in-flight slot being drained this cycle can accept the next request immediately.
  assign elig_if  = IF_REQ && (if_empty || (if_inflight && IF_RREADY));
  assign elig_ls  = LS_REQ && (ls_empty || (ls_inflight && LS_RREADY));
  assign conflict = elig_if && elig_ls;

  always_comb begin
    win_vld = 1'b0;
    winner  = PORT_IF;
    if (conflict) begin
      win_vld = 1'b1;
      winner  = favor_ls ? PORT_LS : PORT_IF;
    end else if (elig_if) begin
      win_vld = 1'b1;
      winner  = PORT_IF;
    end else if (elig_ls) begin
      win_vld = 1'b1;
      winner  = PORT_LS;
    end
  end

  assign win_addr = (winner == PORT_LS) ? LS_ADDR : IF_ADDR;
  assign win_err  = (win_addr[1:0] != 2'b00) || ({1'b0, win_addr} >= ROM_LIMIT);
  assign IF_GNT   = win_vld && (winner == PORT_IF);
  assign LS_GNT   = win_vld && (winner == PORT_LS);
  assign ROM_A    = win_vld ? win_addr : '0;

  // Fairness only moves on a real conflict; the loser is favoured next time.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      favor_ls <= 1'b1;
    end else if (conflict) begin
      favor_ls <= (winner == PORT_IF);
    end
  end

  rom_resp_slot #(
    .DATA_W (DATA_W)
  ) u_if_slot (
    .clk      (CLK),
    .rst_n    (RST_N),
    .gnt      (IF_GNT),
    .gnt_err  (win_err),
    .rready   (IF_RREADY),
    .rom_rd   (ROM_RD),
    .rvalid   (IF_RVALID),
    .rdata    (IF_RDATA),
    .err      (IF_ERR),
    .empty    (if_empty),
    .inflight (if_inflight)
  );

  rom_resp_slot #(
    .DATA_W (DATA_W)
  ) u_ls_slot (
    .clk      (CLK),
    .rst_n    (RST_N),
    .gnt      (LS_GNT),
    .gnt_err  (win_err),
    .rready   (LS_RREADY),
    .rom_rd   (ROM_RD),
    .rvalid   (LS_RVALID),
    .rdata    (LS_RDATA),
    .err      (LS_ERR),
    .empty    (ls_empty),
    .inflight (ls_inflight)
  );

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed scenarios then random traffic against a per-port response model.
module tb_rom_arbiter;

  logic        CLK;
  logic        RST_N;
  logic        IF_REQ;
  logic [31:0] IF_ADDR;
  logic        IF_GNT;
  logic        IF_RVALID;
  logic [31:0] IF_RDATA;
  logic        IF_ERR;
  logic        IF_RREADY;
  logic        LS_REQ;
  logic [31:0] LS_ADDR;
  logic        LS_GNT;
  logic        LS_RVALID;
  logic [31:0] LS_RDATA;
  logic        LS_ERR;
  logic        LS_RREADY;
  logic [31:0] ROM_A;
  logic [31:0] ROM_RD;

  logic [31:0] rom_mem [0:63];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: one outstanding response per port (0 = IF, 1 = LS).
  bit          m_pend  [2];
  bit          m_held  [2];
  bit          m_err   [2];
  logic [31:0] m_dat   [2];
  bit          m_favor_ls;

  rom_arbiter dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IF_REQ    (IF_REQ),
    .IF_ADDR   (IF_ADDR),
    .IF_GNT    (IF_GNT),
    .IF_RVALID (IF_RVALID),
    .IF_RDATA  (IF_RDATA),
    .IF_ERR    (IF_ERR),
    .IF_RREADY (IF_RREADY),
    .LS_REQ    (LS_REQ),
    .LS_ADDR   (LS_ADDR),
    .LS_GNT    (LS_GNT),
    .LS_RVALID (LS_RVALID),
    .LS_RDATA  (LS_RDATA),
    .LS_ERR    (LS_ERR),
    .LS_RREADY (LS_RREADY),
    .ROM_A     (ROM_A),
    .ROM_RD    (ROM_RD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) ROM_RD <= rom_mem[ROM_A[7:2]];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32 * 4);
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_pend[p] = 0;
      m_held[p] = 0;
      m_err[p]  = 0;
      m_dat[p]  = '0;
    end
    m_favor_ls = 1;
  endtask

  // Drive one cycle at the falling edge, compare all outputs, advance the model past the rising edge.
  task automatic step(input logic ir, input logic [31:0] ia, input logic irr,
                      input logic lr, input logic [31:0] la, input logic lrr);
    bit          req  [2];
    logic [31:0] addr [2];
    bit          rr   [2];
    bit          elig [2];
    bit          g    [2];
    logic [31:0] exp_a;
    @(negedge CLK);
    IF_REQ = ir; IF_ADDR = ia; IF_RREADY = irr;
    LS_REQ = lr; LS_ADDR = la; LS_RREADY = lrr;
    #1;
    req[0] = ir;  addr[0] = ia; rr[0] = irr;
    req[1] = lr;  addr[1] = la; rr[1] = lrr;
    for (int p = 0; p < 2; p++)
      elig[p] = req[p] && (!m_pend[p] || (!m_held[p] && rr[p]));
    g[0] = elig[0] && (!elig[1] || !m_favor_ls);
    g[1] = elig[1] && (!elig[0] || m_favor_ls);
    exp_a = g[0] ? ia : (g[1] ? la : 32'h0);
    check_eq("gnt", {62'b0, IF_GNT, LS_GNT}, {62'b0, g[0], g[1]});
    check_eq("rom_a", {32'b0, ROM_A}, {32'b0, exp_a});
    check_eq("if_resp", {30'b0, IF_RVALID, IF_ERR, IF_RDATA},
             {30'b0, m_pend[0], m_pend[0] && m_err[0], m_pend[0] ? m_dat[0] : 32'h0});
    check_eq("ls_resp", {30'b0, LS_RVALID, LS_ERR, LS_RDATA},
             {30'b0, m_pend[1], m_pend[1] && m_err[1], m_pend[1] ? m_dat[1] : 32'h0});
    if (elig[0] && elig[1]) m_favor_ls = g[0];
    for (int p = 0; p < 2; p++) begin
      if (m_pend[p]) begin
        if (rr[p]) m_pend[p] = 0;
        else       m_held[p] = 1;
      end
      if (g[p]) begin
        m_pend[p] = 1;
        m_held[p] = 0;
        m_err[p]  = addr_bad(addr[p]);
        m_dat[p]  = m_err[p] ? 32'h0 : rom_mem[addr[p][6:2]];
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)       return {23'b0, 5'($urandom_range(0, 31)), 2'b00};
    else if (r == 7) return 32'($urandom_range(0, 127));
    else if (r == 8) return 32'($urandom_range(128, 255));
    else             return $urandom;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) rom_mem[i] = $urandom;
    rom_mem[0] = 32'h00100f93;
    rom_mem[1] = 32'h0000408b;
    rom_mem[7] = 32'h04400b13;
    rom_mem[8] = 32'h216000a3;

    RST_N = 1'b0;
    IF_REQ = 0; IF_ADDR = 0; IF_RREADY = 0;
    LS_REQ = 0; LS_ADDR = 0; LS_RREADY = 0;
    model_reset();
    step(0, 0, 0, 0, 0, 0);
    check_eq("reset_outs", {IF_GNT, LS_GNT, IF_RVALID, LS_RVALID, IF_ERR, LS_ERR, 32'(ROM_A != 0)}, 64'h0);
    RST_N = 1'b1;

    // Back-to-back fetches with immediate consume.
    step(1, 32'h0, 1, 0, 0, 1);
    check_eq("tp1_gnt1", {63'b0, IF_GNT}, 64'h1);
    step(1, 32'h4, 1, 0, 0, 1);
    check_eq("tp1_gnt2_data0", {31'b0, IF_GNT, IF_RDATA}, {31'b0, 1'b1, 32'h00100f93});
    step(0, 32'h0, 1, 0, 0, 1);
    check_eq("tp1_data1", {31'b0, IF_RVALID, IF_RDATA}, {31'b0, 1'b1, 32'h0000408b});

    // Continuous conflict: grants alternate starting with LS.
    step(1, 32'h1C, 1, 1, 32'h20, 1);
    check_eq("tp2_first_ls", {62'b0, IF_GNT, LS_GNT}, 64'h1);
    step(1, 32'h1C, 1, 1, 32'h20, 1);
    check_eq("tp2_ls_data", {31'b0, LS_RVALID, LS_RDATA}, {31'b0, 1'b1, 32'h216000a3});
    step(1, 32'h1C, 1, 1, 32'h20, 1);
    check_eq("tp2_if_data", {31'b0, IF_RVALID, IF_RDATA}, {31'b0, 1'b1, 32'h04400b13});
    for (int i = 0; i < 3; i++) step(1, 32'h1C, 1, 1, 32'h20, 1);
    step(0, 0, 1, 0, 0, 1);

    // LS stalls its consumer for three cycles; IF keeps flowing.
    step(0, 0, 1, 1, 32'h1C, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h0, 1, 1, 32'h1C, 0);
      check_eq("tp3_ls_held", {30'b0, LS_GNT, LS_RVALID, LS_RDATA}, {30'b0, 2'b01, 32'h04400b13});
      check_eq("tp3_if_gnt", {63'b0, IF_GNT}, 64'h1);
    end
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);

    // Unaligned and out-of-range LS accesses.
    step(0, 0, 1, 1, 32'h22, 1);
    check_eq("tp4_gnt_unal", {63'b0, LS_GNT}, 64'h1);
    step(0, 0, 1, 1, 32'h80, 1);
    check_eq("tp4_err_unal", {30'b0, LS_RVALID, LS_ERR, LS_RDATA}, {30'b0, 2'b11, 32'h0});
    step(0, 0, 1, 0, 0, 1);
    check_eq("tp4_err_oor", {30'b0, LS_RVALID, LS_ERR, LS_RDATA}, {30'b0, 2'b11, 32'h0});

    // Reset the cycle after an IF grant, then force a conflict.
    step(1, 32'h0, 1, 1, 32'h4, 1);
    step(1, 32'h4, 1, 0, 0, 1);
    @(negedge CLK);
    RST_N = 1'b0;
    model_reset();
    step(0, 0, 1, 0, 0, 1);
    check_eq("tp5_in_reset", {IF_RVALID, LS_RVALID, IF_ERR, LS_ERR, 28'b0, IF_RDATA | LS_RDATA}, 64'h0);
    RST_N = 1'b1;
    step(0, 0, 1, 0, 0, 1);
    check_eq("tp5_no_rvalid", {63'b0, IF_RVALID}, 64'h0);
    step(1, 32'h0, 1, 1, 32'h4, 1);
    check_eq("tp5_ls_first", {62'b0, IF_GNT, LS_GNT}, 64'h1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, rand_addr(), $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 7, rand_addr(), $urandom_range(0, 9) < 6);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
